// File: rtl/demux8_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux8_sched_pkg
// Description : Shared constants, FSM state type and one-hot helper for the
//               8-way demux burst scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package demux8_sched_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    // Lane index to one-hot lane vector.
    function automatic logic [NUM_LANES-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [NUM_LANES-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage : demux8_sched_pkg
`default_nettype wire

// File: rtl/demux8_burst_scheduler_rr_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Combinational rotating-priority picker over 8 requests.
//               The search starts at ptr_i and wraps modulo 8.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
    import demux8_sched_pkg::*;
(
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [SEL_W-1:0]     ptr_i,
    output logic [SEL_W-1:0]     gnt_idx_o,
    output logic                 any_o
);

    // Walk from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        gnt_idx_o = ptr_i;
        any_o     = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (req_i[ptr_i + SEL_W'(i)]) begin
                gnt_idx_o = ptr_i + SEL_W'(i);
                any_o     = 1'b1;
            end
        end
    end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/demux8_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : demux8_burst_scheduler
// Description : Round-robin burst scheduler for an 8-way demux. Each burst
//               (up to BURST_LEN beats, or shorter via in_last) is steered to
//               one ready lane; data is broadcast to all lanes.
//               Optional macro DEMUX8_SCHED_LANE_MASK_EN adds a lane_mask
//               input that restricts which lanes may win arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module demux8_burst_scheduler
    import demux8_sched_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [NUM_LANES-1:0] out_valid,
    output logic [DATA_W-1:0]    out_data,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic                 burst_done
`ifdef DEMUX8_SCHED_LANE_MASK_EN
    ,
    input  logic [NUM_LANES-1:0] lane_mask
`endif
);

    localparam int                c_CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST_LEN - 1);

    sched_state_t         state_q;
    logic [SEL_W-1:0]     ptr_q;
    logic [SEL_W-1:0]     sel_q;
    logic [c_CNT_W-1:0]   beat_cnt_q;
    logic                 burst_done_q;

    logic [NUM_LANES-1:0] w_eligible;
    logic [SEL_W-1:0]     w_gnt_idx;
    logic                 w_any;
    logic                 w_lane_ready;
    logic                 w_accept;
    logic                 w_burst_end;
    logic                 w_xfer_act;

    // Eligibility only matters in ARB, so a mask change mid-burst is harmless.
`ifdef DEMUX8_SCHED_LANE_MASK_EN
    assign w_eligible = out_ready & lane_mask;
`else
    assign w_eligible = out_ready;
`endif

    rr_pick8 u_pick (
        .req_i     (w_eligible),
        .ptr_i     (ptr_q),
        .gnt_idx_o (w_gnt_idx),
        .any_o     (w_any)
    );

    assign w_lane_ready = out_ready[sel_q];
    assign w_accept     = (state_q == XFER) && in_valid && w_lane_ready;
    assign w_burst_end  = in_last || (beat_cnt_q == c_CNT_LAST);
    // Handshake outputs are forced idle while reset is asserted.
    assign w_xfer_act   = (state_q == XFER) && !rst;

    // Scheduler FSM: arbitration, beat counting, round-robin pointer, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            ptr_q        <= '0;
            sel_q        <= '0;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (in_valid && w_any) begin
                        sel_q      <= w_gnt_idx;
                        beat_cnt_q <= '0;
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        if (w_burst_end) begin
                            state_q      <= ARB;
                            ptr_q        <= sel_q + SEL_W'(1);
                            beat_cnt_q   <= '0;
                            burst_done_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + c_CNT_W'(1);
                        end
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign in_ready   = w_xfer_act && w_lane_ready;
    assign out_valid  = w_xfer_act ? (onehot8(sel_q) & {NUM_LANES{in_valid}}) : '0;
    assign out_data   = in_data;
    assign sel        = sel_q;
    assign busy       = w_xfer_act;
    assign burst_done = burst_done_q;

endmodule : demux8_burst_scheduler
`default_nettype wire

// File: tb/tb_demux8_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux8_burst_scheduler
// Description : Self-checking bench for demux8_burst_scheduler (BURST_LEN=4).
//               Table of bursts plus hand-written backpressure, reset and
//               lane-mask sequences; accepted beats checked via scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux8_burst_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_valid;
    logic [7:0] out_data;
    logic [7:0] out_ready;
    logic [2:0] sel;
    logic       busy;
    logic       burst_done;
    logic [7:0] lane_mask;

    always #5 clk = ~clk;

    demux8_burst_scheduler #(.DATA_W(8), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy),
        .burst_done (burst_done)
`ifdef DEMUX8_SCHED_LANE_MASK_EN
        ,
        .lane_mask  (lane_mask)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] lane;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [7:0] ready;
        int         nbeats;
        int         last_idx;
        logic [2:0] lane_a;
        logic [2:0] lane_b;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        sb_t        e;
        logic [7:0] exp_oh;
        if (!rst) begin
            if (in_valid && in_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got out_valid %0h data %0h expected no beat",
                             out_valid, out_data);
                end else begin
                    e      = sb.pop_front();
                    exp_oh = 8'd1 << e.lane;
                    chk("beat_lane", out_valid, exp_oh);
                    chk("beat_data", out_data, e.data);
                end
            end
            if (!busy) chk("idle_gating", {in_ready, out_valid}, 0);
        end
    end

    task automatic drive_beat(input logic [2:0] lane, input logic [7:0] data, input logic last);
        sb_t e;
        bit  ok;
        e.lane = lane;
        e.data = data;
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        ok       = 1'b0;
        for (int t = 0; t < 32 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got in_ready 0 expected 1 (lane %0d)", lane);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_burst_end(input logic [2:0] lane);
        @(negedge clk);
        chk("burst_done", burst_done, 1);
        chk("busy_after_burst", busy, 0);
        chk("sel_after_burst", sel, lane);
        @(negedge clk);
        chk("done_pulse_width", burst_done, 0);
    endtask

    task automatic send_burst(input vec_t v);
        int         len1;
        logic [2:0] lane;
        out_ready = v.ready;
        len1 = (v.last_idx >= 0 && v.last_idx < 4) ? v.last_idx + 1 : 4;
        lane = v.lane_a;
        for (int k = 0; k < v.nbeats; k++) begin
            lane = (k < len1) ? v.lane_a : v.lane_b;
            drive_beat(lane, 8'($urandom), k == v.last_idx);
        end
        check_burst_end(lane);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        // ready, beats, in_last index, lane for first burst, lane for second
        vecs[0] = '{8'hFF, 8, -1, 3'd0, 3'd1};  // two full bursts back-to-back
        vecs[1] = '{8'h20, 4, -1, 3'd5, 3'd5};  // single ready lane 5
        vecs[2] = '{8'hFF, 2,  1, 3'd6, 3'd6};  // early end on 2nd beat
        vecs[3] = '{8'hFF, 3,  2, 3'd7, 3'd7};  // ends on lane 7
        vecs[4] = '{8'hFF, 1,  0, 3'd0, 3'd0};  // pointer wrapped to 0
        vecs[5] = '{8'h81, 4, -1, 3'd7, 3'd7};  // search from 1 finds 7
        vecs[6] = '{8'h81, 2,  1, 3'd0, 3'd0};  // wrap finds 0
        vecs[7] = '{8'h10, 4,  3, 3'd4, 3'd4};  // in_last with count limit
        vecs[8] = '{8'hFF, 2,  1, 3'd5, 3'd5};  // single end: next lane is 5

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 8'hFF;
        lane_mask = 8'hFF;

        // Outputs held idle during reset even with traffic offered.
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("reset_sel", sel, 0);
        chk("reset_burst_done", burst_done, 0);
        chk("reset_busy", busy, 0);

        for (int i = 0; i < 9; i++) send_burst(vecs[i]);

        // Backpressure on lane 6 mid-burst.
        out_ready = 8'hFF;
        drive_beat(3'd6, 8'hA1, 1'b0);
        drive_beat(3'd6, 8'hA2, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'hA3;
        out_ready = 8'hBF;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_sel", sel, 6);
            chk("stall_out_valid", out_valid, 8'h40);
        end
        @(posedge clk);
        #1;
        out_ready = 8'hFF;
        drive_beat(3'd6, 8'hA3, 1'b0);
        drive_beat(3'd6, 8'hA4, 1'b0);
        check_burst_end(3'd6);

        // Reset while beat 2 of a lane-7 burst is offered.
        drive_beat(3'd7, 8'hB1, 1'b0);
        drive_beat(3'd7, 8'hB2, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hB3;
        rst      = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("sb_empty_at_reset", sb.size(), 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", out_valid, 0);
        chk("postrst_sel", sel, 0);
        chk("postrst_busy", busy, 0);
        // Pointer restarted at 0, not 7.
        send_burst('{8'hFF, 4, -1, 3'd0, 3'd0});

`ifdef DEMUX8_SCHED_LANE_MASK_EN
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        lane_mask = 8'h0A;
        send_burst('{8'hFF, 1, 0, 3'd1, 3'd1});
        send_burst('{8'hFF, 1, 0, 3'd3, 3'd3});
        send_burst('{8'hFF, 1, 0, 3'd1, 3'd1});
        send_burst('{8'hFF, 1, 0, 3'd3, 3'd3});
        lane_mask = 8'h00;
        in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("mask0_in_ready", in_ready, 0);
            chk("mask0_busy", busy, 0);
        end
        in_valid = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demux8_burst_scheduler
`default_nettype wire
